// File: rtl/st1_ifid_skid_reg.sv
// IF/ID pipeline register: 2-entry skid buffer between fetch and decode.
// Opcode, immediate field and extension select are decoded on capture and held in flops.
module st1_ifid_skid_reg #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [3:0]        opcode,
  output logic [11:0]       origInstruction,
  output logic [1:0]        SE_Sel,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_count
);

  function automatic logic [1:0] se_sel_f(input logic [3:0] op);
    logic [1:0] sel;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3: sel = 2'b00;
      4'h4, 4'h5, 4'h6, 4'h7: sel = 2'b01;
      4'h8, 4'h9, 4'hA, 4'hB: sel = 2'b10;
      default:                sel = 2'b11;
    endcase
    return sel;
  endfunction

  // Main entry (drives out_*) and skid entry.
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_instr_q, m_instr_d;
  logic [PC_W-1:0]   m_pc_q,    m_pc_d;
  logic [3:0]        m_opc_q,   m_opc_d;
  logic [11:0]       m_fld_q,   m_fld_d;
  logic [1:0]        m_sel_q,   m_sel_d;

  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_instr_q, s_instr_d;
  logic [PC_W-1:0]   s_pc_q,    s_pc_d;
  logic [3:0]        s_opc_q,   s_opc_d;
  logic [11:0]       s_fld_q,   s_fld_d;
  logic [1:0]        s_sel_q,   s_sel_d;

  logic [1:0]        occ_q,     occ_d;
  logic [CNT_W-1:0]  fcnt_q,    fcnt_d;

  logic              accept_s;
  logic              fire_s;
  logic [3:0]        in_opc_s;
  logic [11:0]       in_fld_s;
  logic [1:0]        in_sel_s;

  assign in_opc_s = in_instr[DATA_W-1 -: 4];
  assign in_fld_s = in_instr[11:0];
  assign in_sel_s = se_sel_f(in_opc_s);

  assign accept_s = in_valid & ~s_valid_q;
  assign fire_s   = m_valid_q & out_ready;

  // Next-state selection: flush, then fill/drain of the two entries.
  always_comb begin
    m_valid_d = m_valid_q;
    m_instr_d = m_instr_q;
    m_pc_d    = m_pc_q;
    m_opc_d   = m_opc_q;
    m_fld_d   = m_fld_q;
    m_sel_d   = m_sel_q;
    s_valid_d = s_valid_q;
    s_instr_d = s_instr_q;
    s_pc_d    = s_pc_q;
    s_opc_d   = s_opc_q;
    s_fld_d   = s_fld_q;
    s_sel_d   = s_sel_q;
    fcnt_d    = fcnt_q;

    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      if ((m_valid_q | s_valid_q | accept_s) && (fcnt_q != {CNT_W{1'b1}})) begin
        fcnt_d = fcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        fcnt_d = fcnt_q;
      end
    end else if (!m_valid_q) begin
      if (accept_s) begin
        m_valid_d = 1'b1;
        m_instr_d = in_instr;
        m_pc_d    = in_pc;
        m_opc_d   = in_opc_s;
        m_fld_d   = in_fld_s;
        m_sel_d   = in_sel_s;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (fire_s) begin
      if (s_valid_q) begin
        // Skid word moves up; in_ready was low so nothing new can arrive.
        m_valid_d = 1'b1;
        m_instr_d = s_instr_q;
        m_pc_d    = s_pc_q;
        m_opc_d   = s_opc_q;
        m_fld_d   = s_fld_q;
        m_sel_d   = s_sel_q;
        s_valid_d = 1'b0;
      end else if (accept_s) begin
        m_valid_d = 1'b1;
        m_instr_d = in_instr;
        m_pc_d    = in_pc;
        m_opc_d   = in_opc_s;
        m_fld_d   = in_fld_s;
        m_sel_d   = in_sel_s;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      s_valid_d = 1'b1;
      s_instr_d = in_instr;
      s_pc_d    = in_pc;
      s_opc_d   = in_opc_s;
      s_fld_d   = in_fld_s;
      s_sel_d   = in_sel_s;
    end else begin
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;
    end

    occ_d = {1'b0, m_valid_d} + {1'b0, s_valid_d};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_instr_q <= {DATA_W{1'b0}};
      m_pc_q    <= {PC_W{1'b0}};
      m_opc_q   <= 4'h0;
      m_fld_q   <= 12'h000;
      m_sel_q   <= 2'b00;
      s_valid_q <= 1'b0;
      s_instr_q <= {DATA_W{1'b0}};
      s_pc_q    <= {PC_W{1'b0}};
      s_opc_q   <= 4'h0;
      s_fld_q   <= 12'h000;
      s_sel_q   <= 2'b00;
      occ_q     <= 2'b00;
      fcnt_q    <= {CNT_W{1'b0}};
    end else begin
      m_valid_q <= m_valid_d;
      m_instr_q <= m_instr_d;
      m_pc_q    <= m_pc_d;
      m_opc_q   <= m_opc_d;
      m_fld_q   <= m_fld_d;
      m_sel_q   <= m_sel_d;
      s_valid_q <= s_valid_d;
      s_instr_q <= s_instr_d;
      s_pc_q    <= s_pc_d;
      s_opc_q   <= s_opc_d;
      s_fld_q   <= s_fld_d;
      s_sel_q   <= s_sel_d;
      occ_q     <= occ_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign in_ready        = ~s_valid_q;
  assign out_valid       = m_valid_q;
  assign out_instr       = m_instr_q;
  assign out_pc          = m_pc_q;
  assign opcode          = m_opc_q;
  assign origInstruction = m_fld_q;
  assign SE_Sel          = m_sel_q;
  assign occupancy       = occ_q;
  assign flush_count     = fcnt_q;

endmodule
